// File: rtl/isa_pkg.sv
// Shared RV32I subset definitions: op codes, opcodes, funct fields.
// Used by the encoder, control unit and ALU control.
package isa_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_ADDI = 3'd5
  } op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

endpackage

// File: rtl/instr_pack.sv
// Combinational op + fields -> RV32I word, with illegal/range flags.
// ENC_RANGE_CHECK_EN enables the immediate range check.
module instr_pack
  import isa_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] instr,
  output logic        illegal,
  output logic        range_fail
);

  always_comb begin
    instr   = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  instr = {F7_ADD, rs2, rs1, F3_ADD, rd, OPC_OP};
      OP_SUB:  instr = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_OP};
      OP_LW:   instr = {imm[11:0], rs1, F3_W, rd, OPC_LOAD};
      OP_SW:   instr = {imm[11:5], rs2, rs1, F3_W,
                        imm[4:0], OPC_STORE};
      OP_BEQ:  instr = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                        imm[4:1], imm[11], OPC_BRANCH};
      OP_ADDI: instr = {imm[11:0], rs1, F3_ADD, rd, OPC_OP_IMM};
      default: illegal = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // 12-bit fit means bits 12 and 11 agree; branch range is only parity
  always_comb begin
    range_fail = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_ADDI: range_fail = imm[12] ^ imm[11];
      OP_BEQ:                range_fail = imm[0];
      default:               range_fail = 1'b0;
    endcase
  end
`else
  assign range_fail = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into RV32I words with sequential addresses.
// Optional macro ENC_RANGE_CHECK_EN drops out-of-range immediates.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic [31:0]         pack_word;
  logic                illegal;
  logic                range_fail;

  instr_pack u_pack (
    .op         (in_op),
    .rd         (in_rd),
    .rs1        (in_rs1),
    .rs2        (in_rs2),
    .imm        (in_imm),
    .instr      (pack_word),
    .illegal    (illegal),
    .range_fail (range_fail)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (clear) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (illegal || range_fail) begin
              err_d = 1'b1;
            end else begin
              instr_d = pack_word;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (ADDR_W=2) against a field-arithmetic model.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [12:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    int          a;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_addr = 0;
  logic        exp_err = 1'b0;
  bit          rand_rdy = 1'b0;
  logic        ready_fix = 1'b0;
  bit          holding = 1'b0;
  logic [31:0] prev_instr;
  logic [AW-1:0] prev_addr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] ref_word(int op, int rd, int rs1,
                                           int rs2, int simm);
    longint u12, u13, w;
    u12 = simm & 'hfff;
    u13 = simm & 'h1fff;
    case (op)
      0: w = rs2 * 2**20 + rs1 * 2**15 + rd * 2**7 + 'h33;
      1: w = 'h40000000 + rs2 * 2**20 + rs1 * 2**15 + rd * 2**7 + 'h33;
      2: w = u12 * 2**20 + rs1 * 2**15 + 2 * 2**12 + rd * 2**7 + 'h03;
      3: w = (u12 / 32) * 2**25 + rs2 * 2**20 + rs1 * 2**15
             + 2 * 2**12 + (u12 % 32) * 2**7 + 'h23;
      4: w = ((u13 / 4096) % 2) * 'h80000000
             + ((u13 / 32) % 64) * 2**25 + rs2 * 2**20 + rs1 * 2**15
             + ((u13 / 2) % 16) * 2**8 + ((u13 / 2048) % 2) * 2**7
             + 'h63;
      default: w = u12 * 2**20 + rs1 * 2**15 + rd * 2**7 + 'h13;
    endcase
    return w[31:0];
  endfunction

  function automatic bit bad_req(int op, int simm);
    if (op >= 6) return 1'b1;
`ifdef ENC_RANGE_CHECK_EN
    if ((op == 2 || op == 3 || op == 5) && (simm < -2048 || simm > 2047))
      return 1'b1;
    if (op == 4 && (simm % 2) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : ready_fix;
  end

  // Monitor: pops on each transfer, checks stability while stalled
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && holding) begin
        chk("hold_instr", out_instr, prev_instr);
        chk("hold_addr", 32'(out_addr), 32'(prev_addr));
      end
      if (out_valid && out_ready && !clear) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_instr", out_instr, e.w);
          chk("out_addr", 32'(out_addr), 32'(e.a));
        end
        holding = 1'b0;
      end else if (out_valid) begin
        holding = 1'b1;
        prev_instr = out_instr;
        prev_addr = out_addr;
      end else begin
        holding = 1'b0;
      end
    end
  end

  task automatic send(int op, int rd, int rs1, int rs2, logic [12:0] imm,
                      bit use_gold, logic [31:0] gold);
    int  n;
    int  simm;
    bit  bad;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_op = op[2:0];
    in_rd = rd[4:0];
    in_rs1 = rs1[4:0];
    in_rs2 = rs2[4:0];
    in_imm = imm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    simm = int'($signed(imm));
    bad = bad_req(op, simm);
    if (bad) begin
      exp_err = 1'b1;
    end else begin
      q.push_back('{use_gold ? gold : ref_word(op, rd, rs1, rs2, simm),
                    exp_addr});
      exp_addr = (exp_addr + 1) % (2**AW);
    end
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'(!bad));
    chk("err", 32'(err), 32'(exp_err));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    ready_fix = 1'b1;
    send(0, 3, 1, 2, 13'd0, 1, 32'h002081B3);
    drain();
    send(1, 3, 1, 2, 13'd0, 1, 32'h402081B3);
    send(2, 5, 1, 0, 13'd8, 1, 32'h0080A283);
    drain();

    ready_fix = 1'b0;
    send(3, 0, 1, 2, 13'd12, 1, 32'h0020A623);
    repeat (3) @(negedge clk);
    ready_fix = 1'b1;
    drain();
    send(4, 0, 1, 2, 13'h1FFC, 1, 32'hFE208EE3);
    send(5, 1, 0, 0, 13'h1FFF, 1, 32'hFFF00093);
    drain();

    send(7, 1, 1, 1, 13'd0, 0, 32'd0);
    chk("illegal_addr_hold", 32'(out_addr), 32'(exp_addr));
    send(5, 0, 0, 0, 13'd2048, 1, 32'h80000013);
    drain();

    // clear and out_ready in the same HOLD cycle
    ready_fix = 1'b0;
    send(5, 7, 3, 0, 13'd100, 0, 32'd0);
    ready_fix = 1'b1;
    @(posedge clk);
    #3 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    void'(q.pop_back());
    exp_addr = 0;
    @(negedge clk);
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    chk("clear_out_addr", 32'(out_addr), 32'd0);
    chk("clear_err", 32'(err), 32'(exp_err));

    // async reset while holding a word
    ready_fix = 1'b0;
    send(0, 9, 8, 7, 13'd0, 0, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rsthold_out_valid", 32'(out_valid), 32'd0);
    chk("rsthold_in_ready", 32'(in_ready), 32'd0);
    chk("rsthold_out_instr", out_instr, 32'd0);
    chk("rsthold_out_addr", 32'(out_addr), 32'd0);
    chk("rsthold_err", 32'(err), 32'd0);
    q.delete();
    exp_addr = 0;
    exp_err = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    ready_fix = 1'b1;

    rand_rdy = 1'b1;
    repeat (300) begin
      send($urandom_range(0, 7), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31),
           13'($urandom), 0, 32'd0);
    end
    rand_rdy = 1'b0;
    drain();
    chk("final_err", 32'(err), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
